// File: rtl/hazard_scoreboard.sv
// Hazard unit for the 5-stage pipeline: forwarding, load-use/branch stalls and a per-register
// countdown scoreboard for long-latency ops. Define HAZARD_STATS_EN to add the stall_cycles counter.
module hazard_scoreboard #(
  parameter int REG_W    = 5,
  parameter int NUM_REGS = 32,
  parameter int CNT_W    = 4,
  parameter int STAT_W   = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [REG_W-1:0]  rsD,
  input  logic [REG_W-1:0]  rtD,
  input  logic [REG_W-1:0]  rsE,
  input  logic [REG_W-1:0]  rtE,
  input  logic [REG_W-1:0]  WriteRegE,
  input  logic [REG_W-1:0]  WriteRegM,
  input  logic [REG_W-1:0]  WriteRegW,
  input  logic              RegWriteE,
  input  logic              RegWriteM,
  input  logic              RegWriteW,
  input  logic              MemToRegE,
  input  logic              MemToRegM,
  input  logic              isBranchD,
  input  logic              issueLongD,
  input  logic [REG_W-1:0]  dstD,
  input  logic [CNT_W-1:0]  latD,
  input  logic              memstall,
  output logic [1:0]        forwardAE,
  output logic [1:0]        forwardBE,
  output logic              forwardAD,
  output logic              forwardBD,
  output logic              stallF,
  output logic              stallD,
  output logic              flushE,
  output logic              branchstall,
  output logic              long_done,
  output logic [REG_W-1:0]  long_done_reg,
`ifdef HAZARD_STATS_EN
  output logic              sb_busy,
  output logic [STAT_W-1:0] stall_cycles
`else
  output logic              sb_busy
`endif
);

  logic [CNT_W-1:0] cnt     [NUM_REGS];
  logic [CNT_W-1:0] cntNext [NUM_REGS];
  logic [CNT_W-1:0] effLat;
  logic             lwStall, rawStall, wawStall, portStall, issueNow, anyBusy;
  logic             hitE, hitM, nextDone;
  logic [REG_W-1:0] nextDoneReg;

  assign forwardAE = (rsE != '0 && rsE == WriteRegM && RegWriteM) ? 2'b10 :
                     (rsE != '0 && rsE == WriteRegW && RegWriteW) ? 2'b01 : 2'b00;
  assign forwardBE = (rtE != '0 && rtE == WriteRegM && RegWriteM) ? 2'b10 :
                     (rtE != '0 && rtE == WriteRegW && RegWriteW) ? 2'b01 : 2'b00;
  assign forwardAD = (rsD != '0) && (rsD == WriteRegM) && RegWriteM;
  assign forwardBD = (rtD != '0) && (rtD == WriteRegM) && RegWriteM;

  assign lwStall = MemToRegE && (rsD == rtE || rtD == rtE);
  assign hitE    = (rsD == WriteRegE) || (rtD == WriteRegE);
  assign hitM    = (rsD == WriteRegM) || (rtD == WriteRegM);
  assign branchstall = isBranchD &&
                       ((RegWriteE && WriteRegE != '0 && hitE) ||
                        (MemToRegM && WriteRegM != '0 && hitM));

  assign effLat = (latD == '0) ? CNT_W'(1) : latD;

  // Existing entries decrement on the same edge a new one is written, so an entry now at
  // effLat+1 would land on the same count as the newcomer and expire in the same cycle.
  always_comb begin
    rawStall  = 1'b0;
    wawStall  = 1'b0;
    portStall = 1'b0;
    anyBusy   = 1'b0;
    for (int r = 1; r < NUM_REGS; r++) begin
      if (cnt[r] != '0) begin
        anyBusy = 1'b1;
        if (rsD == REG_W'(r) || rtD == REG_W'(r)) rawStall = 1'b1;
        if (issueLongD && dstD == REG_W'(r)) wawStall = 1'b1;
      end
      if (issueLongD && ({1'b0, cnt[r]} == ({1'b0, effLat} + (CNT_W+1)'(1))))
        portStall = 1'b1;
    end
  end

  assign stallD   = lwStall | branchstall | rawStall | wawStall | portStall | memstall;
  assign stallF   = stallD;
  assign flushE   = stallD & ~memstall;
  assign sb_busy  = anyBusy;
  assign issueNow = issueLongD && !stallD && (dstD != '0);

  // long_done is high during the final cycle of an entry (count 1), just before it clears.
  always_comb begin
    cntNext[0]  = '0;
    nextDone    = 1'b0;
    nextDoneReg = '0;
    for (int r = 1; r < NUM_REGS; r++) begin
      if (issueNow && dstD == REG_W'(r))
        cntNext[r] = effLat;
      else if (cnt[r] != '0)
        cntNext[r] = cnt[r] - CNT_W'(1);
      else
        cntNext[r] = cnt[r];
      if (cntNext[r] == CNT_W'(1)) begin
        nextDone    = 1'b1;
        nextDoneReg = REG_W'(r);
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int r = 0; r < NUM_REGS; r++) cnt[r] <= '0;
      long_done     <= 1'b0;
      long_done_reg <= '0;
    end else begin
      for (int r = 0; r < NUM_REGS; r++) cnt[r] <= cntNext[r];
      long_done     <= nextDone;
      long_done_reg <= nextDoneReg;
    end
  end

`ifdef HAZARD_STATS_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      stall_cycles <= '0;
    else if (stallD && stall_cycles != '1)
      stall_cycles <= stall_cycles + STAT_W'(1);
  end
`endif

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Scoreboard bench for hazard_scoreboard: stimulus queues expectations, a negedge monitor checks them.
module tb_hazard_scoreboard;
  localparam int REG_W = 5;
  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             reset_n;
  logic [REG_W-1:0] rsD, rtD, rsE, rtE, WriteRegE, WriteRegM, WriteRegW, dstD;
  logic             RegWriteE, RegWriteM, RegWriteW, MemToRegE, MemToRegM;
  logic             isBranchD, issueLongD, memstall;
  logic [CNT_W-1:0] latD;
  logic [1:0]       forwardAE, forwardBE;
  logic             forwardAD, forwardBD, stallF, stallD, flushE, branchstall;
  logic             long_done, sb_busy;
  logic [REG_W-1:0] long_done_reg;
`ifdef HAZARD_STATS_EN
  logic [15:0]      stall_cycles;
`endif

  hazard_scoreboard dut (
    .clk(clk), .reset_n(reset_n),
    .rsD(rsD), .rtD(rtD), .rsE(rsE), .rtE(rtE),
    .WriteRegE(WriteRegE), .WriteRegM(WriteRegM), .WriteRegW(WriteRegW),
    .RegWriteE(RegWriteE), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
    .MemToRegE(MemToRegE), .MemToRegM(MemToRegM),
    .isBranchD(isBranchD), .issueLongD(issueLongD), .dstD(dstD), .latD(latD),
    .memstall(memstall),
    .forwardAE(forwardAE), .forwardBE(forwardBE),
    .forwardAD(forwardAD), .forwardBD(forwardBD),
    .stallF(stallF), .stallD(stallD), .flushE(flushE), .branchstall(branchstall),
    .long_done(long_done), .long_done_reg(long_done_reg),
`ifdef HAZARD_STATS_EN
    .sb_busy(sb_busy), .stall_cycles(stall_cycles)
`else
    .sb_busy(sb_busy)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef enum int {S_FAE, S_FBE, S_FAD, S_FBD, S_STALLF, S_STALLD, S_FLUSHE,
                    S_BRST, S_BUSY, S_DONE, S_STAT} sig_e;
  typedef struct { int cyc; string name; sig_e sig; int val; } exp_t;
  typedef struct { int cyc; int dreg; } done_t;

  exp_t  expQ[$];
  done_t doneQ[$];
  int    checks = 0;
  int    passes = 0;

  function automatic int getSig(sig_e s);
    case (s)
      S_FAE:    return int'(forwardAE);
      S_FBE:    return int'(forwardBE);
      S_FAD:    return int'(forwardAD);
      S_FBD:    return int'(forwardBD);
      S_STALLF: return int'(stallF);
      S_STALLD: return int'(stallD);
      S_FLUSHE: return int'(flushE);
      S_BRST:   return int'(branchstall);
      S_BUSY:   return int'(sb_busy);
      S_DONE:   return int'(long_done);
`ifdef HAZARD_STATS_EN
      S_STAT:   return int'(stall_cycles);
`endif
      default:  return -1;
    endcase
  endfunction

  task automatic compare(input string name, input int act, input int req);
    checks++;
    if (act == req) passes++;
    else $display("[TB] FAIL %s: got %0d, required %0d (cycle %0d)", name, act, req, cyc);
  endtask

  task automatic checkOutput(input string name, input sig_e s, input int val);
    expQ.push_back('{cyc, name, s, val});
  endtask

  task automatic expectDone(input int r, input int lat);
    doneQ.push_back('{cyc + lat, r});
  endtask

  // Compare queued expectations for this cycle; every long_done pulse must match a queued expiry.
  always @(negedge clk) begin : monitor
    exp_t  e;
    done_t d;
    while (expQ.size() > 0 && expQ[0].cyc <= cyc) begin
      e = expQ.pop_front();
      compare(e.name, getSig(e.sig), e.val);
    end
    while (doneQ.size() > 0 && doneQ[0].cyc < cyc) begin
      d = doneQ.pop_front();
      compare($sformatf("missed expiry r%0d", d.dreg), 0, 1);
    end
    if (long_done === 1'b1) begin
      if (doneQ.size() > 0 && doneQ[0].cyc == cyc) begin
        d = doneQ.pop_front();
        compare("long_done_reg", int'(long_done_reg), d.dreg);
      end else begin
        compare("unexpected long_done", 1, 0);
      end
    end
  end

  task automatic clearAll();
    rsD = '0; rtD = '0; rsE = '0; rtE = '0;
    WriteRegE = '0; WriteRegM = '0; WriteRegW = '0; dstD = '0;
    RegWriteE = 1'b0; RegWriteM = 1'b0; RegWriteW = 1'b0;
    MemToRegE = 1'b0; MemToRegM = 1'b0; isBranchD = 1'b0;
    issueLongD = 1'b0; memstall = 1'b0; latD = '0;
  endtask

  // Advance one cycle, idle the pipeline, then drive the D-stage fields.
  task automatic applyStimulus(input int rs, input int rt, input int iss,
                               input int dst, input int lat, input int mem);
    @(posedge clk);
    #1;
    clearAll();
    rsD        = REG_W'(rs);
    rtD        = REG_W'(rt);
    issueLongD = (iss != 0);
    dstD       = REG_W'(dst);
    latD       = CNT_W'(lat);
    memstall   = (mem != 0);
  endtask

  initial begin
    reset_n = 1'b1;
    clearAll();
    #2 reset_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset sb_busy", S_BUSY, 0);
    checkOutput("reset long_done", S_DONE, 0);
    checkOutput("reset stallD", S_STALLD, 0);
    reset_n = 1'b1;

    // Forwarding to E and D
    applyStimulus(0, 0, 0, 0, 0, 0);
    rsE = 5'd3; WriteRegM = 5'd3; RegWriteM = 1'b1; WriteRegW = 5'd3; RegWriteW = 1'b1;
    checkOutput("fwdAE M priority", S_FAE, 2);
    checkOutput("fwdBE src0", S_FBE, 0);
    applyStimulus(0, 0, 0, 0, 0, 0);
    rsE = 5'd3; rtE = 5'd3; WriteRegM = 5'd5; RegWriteM = 1'b1; WriteRegW = 5'd3; RegWriteW = 1'b1;
    checkOutput("fwdAE W", S_FAE, 1);
    checkOutput("fwdBE W", S_FBE, 1);
    applyStimulus(0, 0, 0, 0, 0, 0);
    rsE = 5'd0; rtE = 5'd5; WriteRegM = 5'd0; RegWriteM = 1'b1; WriteRegW = 5'd5; RegWriteW = 1'b1;
    checkOutput("fwdAE rs0", S_FAE, 0);
    checkOutput("fwdBE W2", S_FBE, 1);
    applyStimulus(0, 0, 0, 0, 0, 0);
    rsE = 5'd3; WriteRegM = 5'd3; RegWriteM = 1'b0; WriteRegW = 5'd3; RegWriteW = 1'b1;
    checkOutput("fwdAE M no write", S_FAE, 1);
    applyStimulus(5, 6, 0, 0, 0, 0);
    WriteRegM = 5'd5; RegWriteM = 1'b1;
    checkOutput("fwdAD hit", S_FAD, 1);
    checkOutput("fwdBD miss", S_FBD, 0);
    checkOutput("fwd no stall", S_STALLD, 0);
    applyStimulus(0, 0, 0, 0, 0, 0);
    WriteRegM = 5'd0; RegWriteM = 1'b1;
    checkOutput("fwdAD rs0", S_FAD, 0);

    // Load-use for one cycle only
    applyStimulus(4, 0, 0, 0, 0, 0);
    MemToRegE = 1'b1; rtE = 5'd4;
    checkOutput("lw stallF", S_STALLF, 1);
    checkOutput("lw stallD", S_STALLD, 1);
    checkOutput("lw flushE", S_FLUSHE, 1);
    applyStimulus(4, 0, 0, 0, 0, 0);
    rtE = 5'd4;
    checkOutput("lw cleared stallD", S_STALLD, 0);
    checkOutput("lw cleared flushE", S_FLUSHE, 0);

    // Branch stalls
    applyStimulus(6, 0, 0, 0, 0, 0);
    isBranchD = 1'b1; RegWriteE = 1'b1; WriteRegE = 5'd6;
    checkOutput("branch E hit", S_BRST, 1);
    checkOutput("branch E stallD", S_STALLD, 1);
    applyStimulus(0, 0, 0, 0, 0, 0);
    isBranchD = 1'b1; RegWriteE = 1'b1; WriteRegE = 5'd0;
    checkOutput("branch E reg0", S_BRST, 0);
    applyStimulus(0, 6, 0, 0, 0, 0);
    isBranchD = 1'b1; MemToRegM = 1'b1; WriteRegM = 5'd6;
    checkOutput("branch M load hit", S_BRST, 1);
    applyStimulus(0, 6, 0, 0, 0, 0);
    MemToRegM = 1'b1; WriteRegM = 5'd6;
    checkOutput("no branch no stall", S_BRST, 0);

    // Long issue r7 lat 3 with a dependent instruction
    applyStimulus(0, 0, 1, 7, 3, 0);
    checkOutput("issue r7 stallD", S_STALLD, 0);
    checkOutput("issue r7 busy before", S_BUSY, 0);
    expectDone(7, 3);
    applyStimulus(7, 0, 0, 0, 0, 0);
    checkOutput("raw r7 c1", S_STALLD, 1);
    checkOutput("raw r7 busy", S_BUSY, 1);
    checkOutput("raw r7 flushE", S_FLUSHE, 1);
    applyStimulus(7, 0, 0, 0, 0, 0);
    checkOutput("raw r7 c2", S_STALLD, 1);
    applyStimulus(7, 0, 0, 0, 0, 0);
    checkOutput("raw r7 c3", S_STALLD, 1);
    checkOutput("r7 long_done", S_DONE, 1);
    applyStimulus(7, 0, 0, 0, 0, 0);
    checkOutput("raw r7 released", S_STALLD, 0);
    checkOutput("r7 done low", S_DONE, 0);
    checkOutput("r7 idle busy", S_BUSY, 0);

    // Write-port collision
    applyStimulus(0, 0, 1, 7, 4, 0);
    expectDone(7, 4);
    applyStimulus(0, 0, 1, 8, 3, 0);
    checkOutput("portstall", S_STALLD, 1);
    applyStimulus(0, 0, 1, 8, 3, 0);
    checkOutput("r8 issues", S_STALLD, 0);
    expectDone(8, 3);
    applyStimulus(0, 0, 0, 0, 0, 0);
    checkOutput("two pending busy", S_BUSY, 1);
    applyStimulus(0, 0, 0, 0, 0, 0);
    checkOutput("r7 done first", S_DONE, 1);
    applyStimulus(0, 0, 0, 0, 0, 0);
    checkOutput("r8 done next", S_DONE, 1);
    applyStimulus(0, 0, 0, 0, 0, 0);
    checkOutput("collision idle", S_BUSY, 0);

    // memstall freezes without a bubble while the scoreboard keeps counting
    applyStimulus(0, 0, 1, 9, 2, 0);
    expectDone(9, 2);
    applyStimulus(0, 0, 0, 0, 0, 1);
    checkOutput("memstall stallD", S_STALLD, 1);
    checkOutput("memstall stallF", S_STALLF, 1);
    checkOutput("memstall flushE", S_FLUSHE, 0);
    applyStimulus(0, 0, 0, 0, 0, 1);
    checkOutput("memstall expiry", S_DONE, 1);
    applyStimulus(0, 0, 0, 0, 0, 0);
    checkOutput("memstall idle", S_BUSY, 0);

    // Latency 0 behaves as 1; destination 0 is never tracked
    applyStimulus(0, 0, 1, 10, 0, 0);
    expectDone(10, 1);
    applyStimulus(0, 0, 0, 0, 0, 0);
    checkOutput("lat0 busy", S_BUSY, 1);
    checkOutput("lat0 done", S_DONE, 1);
    applyStimulus(0, 0, 1, 0, 5, 0);
    checkOutput("lat0 cleared", S_BUSY, 0);
    applyStimulus(0, 0, 0, 0, 0, 0);
    checkOutput("dst0 not tracked", S_BUSY, 0);

    // WAW stall, then reset discards the pending entry
    applyStimulus(0, 0, 1, 11, 5, 0);
    applyStimulus(0, 0, 1, 11, 2, 0);
    checkOutput("wawstall", S_STALLD, 1);
    applyStimulus(0, 0, 0, 0, 0, 0);
    reset_n = 1'b0;
    checkOutput("reset mid busy", S_BUSY, 0);
    checkOutput("reset mid done", S_DONE, 0);
    applyStimulus(0, 0, 0, 0, 0, 0);
    reset_n = 1'b1;
    repeat (6) applyStimulus(0, 0, 0, 0, 0, 0);
    checkOutput("after reset idle", S_BUSY, 0);

`ifdef HAZARD_STATS_EN
    applyStimulus(0, 0, 0, 0, 0, 0);
    reset_n = 1'b0;
    checkOutput("stat reset", S_STAT, 0);
    applyStimulus(0, 0, 0, 0, 0, 0);
    reset_n = 1'b1;
    applyStimulus(0, 0, 0, 0, 0, 1);
    repeat (3) applyStimulus(0, 0, 0, 0, 0, 1);
    checkOutput("stat count 3", S_STAT, 3);
    repeat (65600) applyStimulus(0, 0, 0, 0, 0, 1);
    checkOutput("stat saturate", S_STAT, 65535);
`endif

    repeat (3) applyStimulus(0, 0, 0, 0, 0, 0);
    @(negedge clk);
    #1;
    compare("pending expiries", doneQ.size(), 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
